// File: rtl/framebuffer_scanout.sv
// framebuffer_scanout: VGA timing, linear read address and pixel-index to 12-bit RGB mapping.
// Define SCANOUT_PALETTE_EN for a writable 16x12 palette (grayscale at reset) instead of the fixed gray map.
module framebuffer_scanout #(
  parameter int H_ACTIVE   = 640,
  parameter int H_FP       = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BP       = 48,
  parameter int V_ACTIVE   = 480,
  parameter int V_FP       = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BP       = 33,
  parameter int PIX_DIV    = 4,
  parameter int RD_LATENCY = 1
) (
  input  logic        clock,
  input  logic        reset,
  output logic [18:0] addr_vga,
  input  logic [3:0]  data_vga,
  output logic        vga_hsync,
  output logic        vga_vsync,
  output logic [3:0]  vga_r,
  output logic [3:0]  vga_g,
  output logic [3:0]  vga_b,
  output logic        frame_start
`ifdef SCANOUT_PALETTE_EN
  ,
  input  logic        pal_we,
  input  logic [3:0]  pal_addr,
  input  logic [11:0] pal_data
`endif
);
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW = $clog2(H_TOTAL);
  localparam int VW = $clog2(V_TOTAL);
  localparam int DW = $clog2(PIX_DIV + 1);
  logic [DW-1:0] div;
  logic [HW-1:0] h;
  logic [VW-1:0] v;
  logic tick, first, act, hs, vs, h_last, v_last;
  logic active0, hs0, vs0;
  logic [3:0] pix1;
  logic [11:0] colour;
  always_comb begin
    tick   = div == DW'(PIX_DIV - 1);
    first  = h == '0 && v == '0;
    h_last = h == HW'(H_TOTAL - 1);
    v_last = v == VW'(V_TOTAL - 1);
    act    = h < HW'(H_ACTIVE) && v < VW'(V_ACTIVE);
    hs     = !(h >= HW'(H_ACTIVE + H_FP) && h < HW'(H_ACTIVE + H_FP + H_SYNC));
    vs     = !(v >= VW'(V_ACTIVE + V_FP) && v < VW'(V_ACTIVE + V_FP + V_SYNC));
  end
`ifdef SCANOUT_PALETTE_EN
  logic [11:0] pal [16];
  // Lookup happens on the same edge as a write, so a same-tick write shows the old entry.
  always_ff @(posedge clock or posedge reset)
    if (reset)
      for (int i = 0; i < 16; i++) pal[i] <= {3{4'(i)}};
    else if (pal_we)
      pal[pal_addr] <= pal_data;
  always_comb colour = pal[pix1];
`else
  always_comb colour = {3{pix1}};
`endif
  // Counters hold the next position to issue; each tick issues it and advances.
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      div         <= '0;
      h           <= '0;
      v           <= '0;
      addr_vga    <= '0;
      active0     <= 1'b0;
      hs0         <= 1'b1;
      vs0         <= 1'b1;
      pix1        <= '0;
      vga_hsync   <= 1'b1;
      vga_vsync   <= 1'b1;
      {vga_r, vga_g, vga_b} <= '0;
      frame_start <= 1'b0;
    end else begin
      div         <= tick ? '0 : div + 1'b1;
      frame_start <= tick && first;
      if (div == DW'(RD_LATENCY)) pix1 <= data_vga;
      if (tick) begin
        h         <= h_last ? '0 : h + 1'b1;
        v         <= h_last ? (v_last ? '0 : v + 1'b1) : v;
        active0   <= act;
        hs0       <= hs;
        vs0       <= vs;
        addr_vga  <= first ? '0 : act ? addr_vga + 1'b1 : addr_vga;
        vga_hsync <= hs0;
        vga_vsync <= vs0;
        {vga_r, vga_g, vga_b} <= active0 ? colour : 12'h000;
      end
    end
endmodule
